// File: rtl/ll_pop_scheduler.sv
// ll_pop_scheduler
// Pops the linked-list shared FIFO with work-conserving round-robin across
// the eligible queues. Each popped word is tagged with its queue id and held
// in a 2-entry output buffer that the sink drains with valid/ready.
// pop depends only on registered buffer occupancy, so out_ready has no
// combinational path to the FIFO side.
module ll_pop_scheduler #(
    parameter int WIDTH     = 8,
    parameter int NUM_FIFOS = 2,
    parameter int SEL_WIDTH = $clog2(NUM_FIFOS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_FIFOS-1:0] empty,
    input  logic [WIDTH-1:0]     ll_data,
    input  logic [NUM_FIFOS-1:0] qmask,
    output logic                 pop,
    output logic [SEL_WIDTH-1:0] pop_sel,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SEL_WIDTH-1:0] out_qid,
    input  logic                 out_ready,
    output logic                 busy
);

    // Search arithmetic runs one bit wider, so rr_ptr + NUM_FIFOS cannot overflow.
    localparam int CW = SEL_WIDTH + 1;

    logic [SEL_WIDTH-1:0] rr_ptr_r;
    logic [WIDTH-1:0]     slot_data_r [2];
    logic [SEL_WIDTH-1:0] slot_qid_r  [2];
    logic                 rd_idx_r;
    logic                 wr_idx_r;
    logic [1:0]           cnt_r;

    logic [NUM_FIFOS-1:0] elig_s;
    logic [SEL_WIDTH-1:0] winner_s;
    logic                 found_s;
    logic [CW-1:0]        cand_s;
    logic [SEL_WIDTH-1:0] cand_sel_s;
    logic                 pop_s;
    logic                 out_valid_s;
    logic                 xfer_s;

    assign elig_s = ~empty & qmask;

    // Round-robin search starting after rr_ptr, wrapping explicitly modulo NUM_FIFOS.
    // rr_ptr itself is visited last.
    always_comb begin
        winner_s   = rr_ptr_r;
        found_s    = 1'b0;
        cand_s     = {CW{1'b0}};
        cand_sel_s = {SEL_WIDTH{1'b0}};
        for (int k = 1; k <= NUM_FIFOS; k++) begin
            cand_s = {1'b0, rr_ptr_r} + CW'(k);
            if (cand_s >= CW'(NUM_FIFOS)) begin
                cand_s = cand_s - CW'(NUM_FIFOS);
            end else begin
                cand_s = cand_s;
            end
            cand_sel_s = cand_s[SEL_WIDTH-1:0];
            if (!found_s && elig_s[cand_sel_s]) begin
                found_s  = 1'b1;
                winner_s = cand_sel_s;
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Pop issue uses only the registered occupancy. pop_sel parks on the last winner when idle.
    always_comb begin
        pop_s       = rst & (|elig_s) & (cnt_r < 2'd2);
        out_valid_s = rst & (cnt_r != 2'd0);
        xfer_s      = out_valid_s & out_ready;
        if (pop_s) begin
            pop_sel = winner_s;
        end else begin
            pop_sel = rr_ptr_r;
        end
    end

    assign pop       = pop_s;
    assign out_valid = out_valid_s;
    assign out_data  = slot_data_r[rd_idx_r];
    assign out_qid   = slot_qid_r[rd_idx_r];
    assign busy      = rst & (out_valid_s | (|elig_s));

    // Control state: round-robin pointer, buffer indices and occupancy.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr_r <= SEL_WIDTH'(NUM_FIFOS - 1);
            rd_idx_r <= 1'b0;
            wr_idx_r <= 1'b0;
            cnt_r    <= 2'd0;
        end else begin
            if (pop_s) begin
                rr_ptr_r <= pop_sel;
                wr_idx_r <= ~wr_idx_r;
            end else begin
                rr_ptr_r <= rr_ptr_r;
                wr_idx_r <= wr_idx_r;
            end
            if (xfer_s) begin
                rd_idx_r <= ~rd_idx_r;
            end else begin
                rd_idx_r <= rd_idx_r;
            end
            case ({pop_s, xfer_s})
                2'b10:   cnt_r <= cnt_r + 2'd1;
                2'b01:   cnt_r <= cnt_r - 2'd1;
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // Buffer storage: contents are don't-care after reset, so only pop writes them.
    always_ff @(posedge clk) begin
        if (pop_s) begin
            slot_data_r[wr_idx_r] <= ll_data;
            slot_qid_r[wr_idx_r]  <= pop_sel;
        end else begin
            slot_data_r[wr_idx_r] <= slot_data_r[wr_idx_r];
            slot_qid_r[wr_idx_r]  <= slot_qid_r[wr_idx_r];
        end
    end

endmodule

// File: tb/tb_ll_pop_scheduler.sv
// tb_ll_pop_scheduler
// Directed, table-driven bench for ll_pop_scheduler with NUM_FIFOS=3.
// Each table row is one clock cycle: inputs are driven after the falling edge,
// and outputs are compared just before the next rising edge.
module tb_ll_pop_scheduler;

    logic       clk;
    logic       rst;
    logic [2:0] empty;
    logic [7:0] ll_data;
    logic [2:0] qmask;
    logic       pop;
    logic [1:0] pop_sel;
    logic       out_valid;
    logic [7:0] out_data;
    logic [1:0] out_qid;
    logic       out_ready;
    logic       busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       rst;
        logic [2:0] empty;
        logic [2:0] qmask;
        logic       rdy;
        logic [7:0] din;
        logic       e_pop;
        logic [1:0] e_sel;
        logic       sel_chk;
        logic       e_ov;
        logic [7:0] e_od;
        logic [1:0] e_oq;
        logic       e_busy;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    logic [7:0] prev_d;
    logic [1:0] prev_q;
    logic [1:0] exp_sel;

    ll_pop_scheduler #(.WIDTH(8), .NUM_FIFOS(3)) dut (
        .clk(clk), .rst(rst), .empty(empty), .ll_data(ll_data), .qmask(qmask),
        .pop(pop), .pop_sel(pop_sel), .out_valid(out_valid), .out_data(out_data),
        .out_qid(out_qid), .out_ready(out_ready), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(input logic r, input logic [2:0] e, input logic [2:0] m,
                                input logic rd, input logic [7:0] d, input logic p,
                                input logic [1:0] s, input logic sc, input logic ov,
                                input logic [7:0] od, input logic [1:0] oq, input logic b);
        vec_t v;
        v.rst = r; v.empty = e; v.qmask = m; v.rdy = rd; v.din = d;
        v.e_pop = p; v.e_sel = s; v.sel_chk = sc; v.e_ov = ov;
        v.e_od = od; v.e_oq = oq; v.e_busy = b;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        rst = 1'b0; empty = 3'b000; qmask = 3'b111; ll_data = 8'h00; out_ready = 1'b0;

        //          rst   empty   qmask   rdy   din     pop   sel   chk   ov    od      oq    busy
        vecs[0]  = mk(1'b0, 3'b000, 3'b111, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0);
        vecs[1]  = mk(1'b0, 3'b000, 3'b111, 1'b0, 8'h00, 1'b0, 2'd2, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0);
        vecs[2]  = mk(1'b0, 3'b000, 3'b111, 1'b0, 8'h00, 1'b0, 2'd2, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0);
        // release: queue 0 first, then fill the buffer under backpressure
        vecs[3]  = mk(1'b1, 3'b000, 3'b111, 1'b0, 8'hA0, 1'b1, 2'd0, 1'b1, 1'b0, 8'h00, 2'd0, 1'b1);
        vecs[4]  = mk(1'b1, 3'b000, 3'b111, 1'b0, 8'hB1, 1'b1, 2'd1, 1'b1, 1'b1, 8'hA0, 2'd0, 1'b1);
        vecs[5]  = mk(1'b1, 3'b000, 3'b111, 1'b0, 8'hC2, 1'b0, 2'd1, 1'b1, 1'b1, 8'hA0, 2'd0, 1'b1);
        // full buffer stalls pop even with ready high
        vecs[6]  = mk(1'b1, 3'b000, 3'b111, 1'b1, 8'hC2, 1'b0, 2'd1, 1'b1, 1'b1, 8'hA0, 2'd0, 1'b1);
        vecs[7]  = mk(1'b1, 3'b000, 3'b111, 1'b1, 8'hC2, 1'b1, 2'd2, 1'b1, 1'b1, 8'hB1, 2'd1, 1'b1);
        vecs[8]  = mk(1'b1, 3'b000, 3'b111, 1'b1, 8'hD0, 1'b1, 2'd0, 1'b1, 1'b1, 8'hC2, 2'd2, 1'b1);
        // queue 1 masked: alternate 2,0,2
        vecs[9]  = mk(1'b1, 3'b000, 3'b101, 1'b1, 8'hE2, 1'b1, 2'd2, 1'b1, 1'b1, 8'hD0, 2'd0, 1'b1);
        vecs[10] = mk(1'b1, 3'b000, 3'b101, 1'b1, 8'hF0, 1'b1, 2'd0, 1'b1, 1'b1, 8'hE2, 2'd2, 1'b1);
        vecs[11] = mk(1'b1, 3'b000, 3'b101, 1'b1, 8'h62, 1'b1, 2'd2, 1'b1, 1'b1, 8'hF0, 2'd0, 1'b1);
        // single eligible queue (2), which is also rr_ptr
        vecs[12] = mk(1'b1, 3'b011, 3'b111, 1'b1, 8'h72, 1'b1, 2'd2, 1'b1, 1'b1, 8'h62, 2'd2, 1'b1);
        vecs[13] = mk(1'b1, 3'b011, 3'b111, 1'b1, 8'h82, 1'b1, 2'd2, 1'b1, 1'b1, 8'h72, 2'd2, 1'b1);
        // all empty, then all masked; ready with nothing buffered is ignored
        vecs[14] = mk(1'b1, 3'b111, 3'b111, 1'b1, 8'h00, 1'b0, 2'd2, 1'b1, 1'b1, 8'h82, 2'd2, 1'b1);
        vecs[15] = mk(1'b1, 3'b111, 3'b111, 1'b1, 8'h00, 1'b0, 2'd2, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0);
        vecs[16] = mk(1'b1, 3'b000, 3'b000, 1'b1, 8'h00, 1'b0, 2'd2, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0);
        vecs[17] = mk(1'b1, 3'b000, 3'b010, 1'b0, 8'h91, 1'b1, 2'd1, 1'b1, 1'b0, 8'h00, 2'd0, 1'b1);
        vecs[18] = mk(1'b1, 3'b000, 3'b111, 1'b0, 8'h13, 1'b1, 2'd2, 1'b1, 1'b1, 8'h91, 2'd1, 1'b1);
        // reset with a full buffer discards both words
        vecs[19] = mk(1'b0, 3'b000, 3'b111, 1'b0, 8'h00, 1'b0, 2'd2, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0);
        vecs[20] = mk(1'b1, 3'b000, 3'b111, 1'b1, 8'h24, 1'b1, 2'd0, 1'b1, 1'b0, 8'h00, 2'd0, 1'b1);
        vecs[21] = mk(1'b1, 3'b000, 3'b111, 1'b1, 8'h35, 1'b1, 2'd1, 1'b1, 1'b1, 8'h24, 2'd0, 1'b1);
        vecs[22] = mk(1'b1, 3'b000, 3'b111, 1'b1, 8'h46, 1'b1, 2'd2, 1'b1, 1'b1, 8'h35, 2'd1, 1'b1);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst = vecs[i].rst; empty = vecs[i].empty; qmask = vecs[i].qmask;
            out_ready = vecs[i].rdy; ll_data = vecs[i].din;
            #1;
            check($sformatf("v%0d pop", i), 32'(pop), 32'(vecs[i].e_pop));
            check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
            check($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
            if (vecs[i].sel_chk) begin
                check($sformatf("v%0d pop_sel", i), 32'(pop_sel), 32'(vecs[i].e_sel));
            end
            if (vecs[i].e_ov) begin
                check($sformatf("v%0d out_data", i), 32'(out_data), 32'(vecs[i].e_od));
                check($sformatf("v%0d out_qid", i), 32'(out_qid), 32'(vecs[i].e_oq));
            end
        end

        // Sustained one-word-per-cycle streaming with simultaneous pop and transfer.
        prev_d = 8'h46;
        prev_q = 2'd2;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rst = 1'b1; empty = 3'b000; qmask = 3'b111; out_ready = 1'b1;
            ll_data = 8'h30 + 8'(i);
            exp_sel = 2'(i % 3);
            #1;
            check($sformatf("s%0d pop", i), 32'(pop), 32'(1'b1));
            check($sformatf("s%0d pop_sel", i), 32'(pop_sel), 32'(exp_sel));
            check($sformatf("s%0d out_valid", i), 32'(out_valid), 32'(1'b1));
            check($sformatf("s%0d out_data", i), 32'(out_data), 32'(prev_d));
            check($sformatf("s%0d out_qid", i), 32'(out_qid), 32'(prev_q));
            prev_d = ll_data;
            prev_q = exp_sel;
        end

        // Drain: the last word stays put under backpressure, then leaves.
        @(negedge clk);
        empty = 3'b111; out_ready = 1'b0;
        #1;
        check("drain hold pop", 32'(pop), 32'(1'b0));
        check("drain hold valid", 32'(out_valid), 32'(1'b1));
        check("drain hold data", 32'(out_data), 32'(8'h39));
        check("drain hold qid", 32'(out_qid), 32'(2'd0));
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check("drain ready valid", 32'(out_valid), 32'(1'b1));
        check("drain ready data", 32'(out_data), 32'(8'h39));
        @(negedge clk);
        #1;
        check("drain done valid", 32'(out_valid), 32'(1'b0));
        check("drain done busy", 32'(busy), 32'(1'b0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ll_pop_scheduler.md
Name: ll_pop_scheduler

Overview:
- Downstream consumer of the linked-list shared FIFO (NUM_FIFOS logical queues in shared storage).
- Watches the FIFO's per-queue empty flags and issues pop/pop_sel using work-conserving round-robin across queues.
- Captures the popped word, tagged with its queue id, into a 2-entry output buffer with a valid/ready handshake.
- out_ready never reaches pop combinationally: the FIFO-side timing path is fully decoupled from the sink.

Parameters:
- WIDTH, 8, data word width; must match the shared FIFO.
- NUM_FIFOS, 2, number of logical queues; any value >= 2, not required to be a power of two.
- SEL_WIDTH, $clog2(NUM_FIFOS), width of pop_sel and out_qid.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-low reset (0 = reset).
- empty  input  NUM_FIFOS  per-queue empty flags from the shared FIFO.
- ll_data  input  WIDTH  head word of queue pop_sel, presented combinationally by the FIFO.
- qmask  input  NUM_FIFOS  per-queue service enable; 1 = queue eligible.
- pop  output  1  pop strobe to the shared FIFO.
- pop_sel  output  SEL_WIDTH  queue being popped.
- out_valid  output  1  output buffer holds a word.
- out_data  output  WIDTH  oldest buffered word.
- out_qid  output  SEL_WIDTH  queue id of out_data.
- out_ready  input  1  sink accepts out_data this cycle.
- busy  output  1  out_valid OR any eligible queue.

Behaviour:
- State:
  - rr_ptr [SEL_WIDTH]: last queue served.
  - 2-entry buffer of {data, qid}.
  - rd_idx (1 bit), wr_idx (1 bit).
  - cnt (0..2).
- Reset (rst==0 at posedge):
  - rr_ptr=NUM_FIFOS-1, so queue 0 has first priority.
  - cnt=0, rd_idx=0, wr_idx=0.
  - Buffer contents are don't-care.
  - While rst==0: pop=0, out_valid=0, busy=0, out_data/out_qid don't-care.
- Eligibility: elig[i] = ~empty[i] & qmask[i].
- Arbitration (combinational):
  - Search i = rr_ptr+1, rr_ptr+2, ... modulo NUM_FIFOS; winner is the first i with elig[i].
  - Wrap is explicit mod NUM_FIFOS: pop_sel never reaches a value >= NUM_FIFOS, including for non-power-of-two NUM_FIFOS.
  - rr_ptr itself is searched last.
- Pop issue:
  - pop = rst & (|elig) & (cnt<2).
  - pop_sel = winner when pop=1; when pop=0 it holds the last winner (no spurious toggling).
  - cnt<2 uses registered cnt only; out_ready is not used.
- On posedge with pop=1:
  - buf[wr_idx] <= {ll_data, pop_sel}.
  - wr_idx toggles.
  - rr_ptr <= pop_sel.
  - Latency: a popped word appears at out_data the next cycle when the buffer was empty.
- Output:
  - out_valid = (cnt!=0).
  - out_data/out_qid = buf[rd_idx].
  - Transfer on out_valid & out_ready: rd_idx toggles.
- Count update:
  - pop only: cnt+1.
  - Transfer only: cnt-1.
  - Both in the same cycle: cnt unchanged, and both indices toggle.
- Throughput: one word per cycle is sustained while the sink is ready every cycle. When cnt==2, pop stalls even if out_ready=1 that cycle; this is the price of the registered ready path.
- Boundaries:
  - All queues empty or masked: pop=0, rr_ptr holds.
  - qmask clearing a queue mid-stream: that queue is skipped from the next arbitration onward. Words already buffered still drain.
  - Single eligible queue: it is granted every cycle the buffer has space.
  - Buffer full with out_ready=0: pop=0, contents and order are preserved.
  - out_ready while out_valid=0: ignored.
  - Reset asserted mid-operation: buffered words are discarded and the state reinitialises on that edge.
- Ordering:
  - Per-queue FIFO order is preserved.
  - Words leave the buffer in exactly the order they were popped.

Test Plan:
- Reset: hold rst=0 three cycles with empty=2'b00 -> pop=0, out_valid=0 throughout. Release rst=1 -> pop=1, pop_sel=0 in the first cycle.
- Round-robin, NUM_FIFOS=3: queues 0,1,2 each hold 2 words, qmask=3'b111, out_ready=1 -> pop_sel sequence 0,1,2,0,1,2, one pop per cycle. out_qid matches that sequence one cycle later.
- Backpressure: out_ready=0 with words available -> exactly 2 pops, then pop=0 and out_valid=1 holding word A. Raise out_ready -> A then B delivered in order, and pops resume.
- Masking/skip, NUM_FIFOS=3: empty=3'b000, qmask=3'b101 -> pop_sel alternates 0,2,0,2. Queue 1 is never popped.
- Simultaneous push/transfer with cnt=1, out_ready=1, one word popped per cycle -> cnt stays 1 for 10 cycles. Data matches the popped sequence exactly.
- Mid-stream reset with cnt=2: assert rst=0 for one cycle -> out_valid=0 the next cycle. First grant after release is queue 0 if eligible.
